// File: rtl/md_pkg.sv
// Shared op codes, default sizes and constants for the HI/LO multiply/divide unit.
package md_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_ITER  = 32;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam logic [31:0] MD_DIV0_LO = 32'hFFFF_FFFF;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } md_state_e;

endpackage

// File: rtl/md_iter_core.sv
// Unsigned radix-2 datapath: shift-add multiply or restoring divide, one step per enabled edge.
module md_iter_core #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   mag_a,
  input  logic [WIDTH-1:0]   mag_b,
  output logic [2*WIDTH-1:0] result,
  output logic               last_step
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               div_q, div_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ok;
  logic [WIDTH-1:0]   div_rem;

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient};
  // result is the value acc takes after the current step.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opb_q};
    div_ok    = ~div_diff[WIDTH+1];
    div_rem   = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    if (div_q)
      result = {div_rem, acc_q[WIDTH-2:0], div_ok};
    else
      result = {mul_sum, acc_q[WIDTH-1:1]};
    last_step = (cnt_q == CW'(ITER - 1));
  end

  always_comb begin
    acc_d = acc_q;
    opb_d = opb_q;
    div_d = div_q;
    cnt_d = cnt_q;
    if (start) begin
      acc_d = {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
      opb_d = is_div ? mag_b : mag_a;
      div_d = is_div;
      cnt_d = '0;
    end else if (step) begin
      acc_d = result;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      opb_q <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      opb_q <= opb_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Architectural HI/LO registers with an iterative signed/unsigned multiply/divide engine.
module hilo_muldiv_unit
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int ITER  = MD_ITER
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             md_start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             flush,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done
);

  md_state_e state_q, state_d;

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;
  logic             div_q, div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div0_q, div0_d;

  logic             is_md, signed_op, div_op, accept, core_start, core_step, finish;
  logic             a_neg, b_neg, last_step;
  logic [WIDTH-1:0] mag_a, mag_b, quot, rem;
  logic [2*WIDTH-1:0] core_result, prod;

  always_comb begin
    is_md     = 1'b0;
    signed_op = 1'b0;
    div_op    = 1'b0;
    case (md_op)
      MD_MULT:  begin is_md = 1'b1; signed_op = 1'b1; end
      MD_MULTU: is_md = 1'b1;
      MD_DIV:   begin is_md = 1'b1; signed_op = 1'b1; div_op = 1'b1; end
      MD_DIVU:  begin is_md = 1'b1; div_op = 1'b1; end
      default:  ;
    endcase
    accept     = md_start && (state_q == ST_IDLE) && !flush;
    core_start = accept && is_md;
    core_step  = (state_q == ST_RUN) && !flush;
    finish     = core_step && last_step;
    a_neg      = signed_op && srcA[WIDTH-1];
    b_neg      = signed_op && srcB[WIDTH-1];
    mag_a      = a_neg ? -srcA : srcA;
    mag_b      = b_neg ? -srcB : srcB;
  end

  md_iter_core #(.WIDTH(WIDTH), .ITER(ITER)) u_core (
    .clk       (clk),
    .rst       (rst),
    .start     (core_start),
    .step      (core_step),
    .is_div    (div_op),
    .mag_a     (mag_a),
    .mag_b     (mag_b),
    .result    (core_result),
    .last_step (last_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (core_start) state_d = ST_RUN;
      ST_RUN:  if (flush || last_step) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_RUN);
    HI   = hi_q;
    LO   = lo_q;
    done = done_q;
  end

  // A zero divisor leaves the dividend magnitude in the remainder, so the usual
  // remainder sign fix-up already reproduces srcA for HI.
  always_comb begin
    prod = neg_res_q ? -core_result : core_result;
    quot = neg_res_q ? -core_result[WIDTH-1:0] : core_result[WIDTH-1:0];
    rem  = neg_rem_q ? -core_result[2*WIDTH-1:WIDTH] : core_result[2*WIDTH-1:WIDTH];

    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = finish;
    div_d     = div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;

    if (finish) begin
      if (div_q) begin
        hi_d = rem;
        lo_d = div0_q ? WIDTH'(MD_DIV0_LO) : quot;
      end else begin
        hi_d = prod[2*WIDTH-1:WIDTH];
        lo_d = prod[WIDTH-1:0];
      end
    end else if (accept && md_op == MD_MTHI) begin
      hi_d = srcA;
    end else if (accept && md_op == MD_MTLO) begin
      lo_d = srcA;
    end

    if (core_start) begin
      div_d     = div_op;
      neg_res_d = a_neg ^ b_neg;
      neg_rem_d = div_op && a_neg;
      div0_d    = div_op && (srcB == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      div_q     <= div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed testbench for hilo_muldiv_unit with hand-computed expected results.
module tb_hilo_muldiv_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        md_start;
  logic [2:0]  md_op;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        flush;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;
  logic        done;

  int vectors     = 0;
  int miscompares = 0;

  hilo_muldiv_unit dut (
    .clk      (clk),
    .rst      (rst),
    .md_start (md_start),
    .md_op    (md_op),
    .srcA     (srcA),
    .srcB     (srcB),
    .flush    (flush),
    .HI       (HI),
    .LO       (LO),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Presents a request for one cycle; caller is positioned on a falling edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    md_start = 1'b1;
    md_op    = op;
    srcA     = a;
    srcB     = b;
    @(negedge clk);
    md_start = 1'b0;
    md_op    = MD_NONE;
  endtask

  // Counts cycles (cycle 0 = request cycle) until done, bounded; flags any
  // change of HI/LO or drop of busy before done.
  task automatic wait_for_done(input int start_cycle, output int n, output bit leak);
    logic [31:0] hi0, lo0;
    hi0  = HI;
    lo0  = LO;
    n    = -1;
    leak = 1'b0;
    for (int i = start_cycle; i <= start_cycle + 64; i++) begin
      if (done === 1'b1) begin
        n = i;
        break;
      end
      if (busy !== 1'b1 || HI !== hi0 || LO !== lo0) leak = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; md_start = 1'b0; md_op = MD_NONE; srcA = '0; srcB = '0; flush = 1'b0;
    #12;
    vectors++;
    if (HI !== 32'h0 || LO !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: HI=%h LO=%h busy=%b done=%b, expected all zero", HI, LO, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mthi_mtlo;
    issue(MD_MTHI, 32'h0000DEAD, 32'h0);
    vectors++;
    if (HI !== 32'h0000DEAD || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL mthi: HI=%h busy=%b done=%b, expected HI=0000dead busy=0 done=0", HI, busy, done);
    end
    issue(MD_MTLO, 32'h0000BEEF, 32'h0);
    vectors++;
    if (HI !== 32'h0000DEAD || LO !== 32'h0000BEEF || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL mtlo: HI=%h LO=%h busy=%b done=%b, expected 0000dead 0000beef 0 0", HI, LO, busy, done);
    end
    issue(3'd7, 32'h12345678, 32'h0);
    vectors++;
    if (HI !== 32'h0000DEAD || LO !== 32'h0000BEEF || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reserved_op: HI=%h LO=%h busy=%b, expected 0000dead 0000beef 0", HI, LO, busy);
    end
  endtask

  task automatic test_mult;
    int n; bit leak;
    issue(MD_MULT, 32'hFFFFFFFD, 32'd7);
    wait_for_done(1, n, leak);
    vectors++;
    if (n !== 33 || leak) begin
      miscompares++;
      $display("FAIL mult_timing: done at cycle %0d leak=%b, expected cycle 33 leak=0", n, leak);
    end
    vectors++;
    if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFEB || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mult_result: HI=%h LO=%h busy=%b, expected ffffffff ffffffeb 0", HI, LO, busy);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL mult_done_pulse: done=%b one cycle later, expected 0", done);
    end
  endtask

  task automatic test_back_to_back;
    int n; bit leak;
    issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_for_done(1, n, leak);
    vectors++;
    if (n !== 33 || HI !== 32'hFFFFFFFE || LO !== 32'h00000001) begin
      miscompares++;
      $display("FAIL multu_max: cycle %0d HI=%h LO=%h, expected 33 fffffffe 00000001", n, HI, LO);
    end
    issue(MD_MULTU, 32'd2, 32'd3);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_accept: busy=%b, expected 1", busy);
    end
    wait_for_done(1, n, leak);
    vectors++;
    if (n !== 33 || leak || HI !== 32'h0 || LO !== 32'h6) begin
      miscompares++;
      $display("FAIL b2b_result: cycle %0d leak=%b HI=%h LO=%h, expected 33 0 0 6", n, leak, HI, LO);
    end
    @(negedge clk);
  endtask

  task automatic test_divide;
    logic [2:0]  ops [6] = '{MD_DIV, MD_DIV, MD_DIVU, MD_DIV, MD_DIV, MD_DIVU};
    logic [31:0] as  [6] = '{32'hFFFFFFF9, 32'h80000000, 32'd100, 32'd7, 32'hFFFFFFFB, 32'd100};
    logic [31:0] bs  [6] = '{32'd2, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFE, 32'd0, 32'd7};
    logic [31:0] ehi [6] = '{32'hFFFFFFFF, 32'h0, 32'd100, 32'd1, 32'hFFFFFFFB, 32'd2};
    logic [31:0] elo [6] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14};
    int n; bit leak;
    for (int k = 0; k < 6; k++) begin
      issue(ops[k], as[k], bs[k]);
      wait_for_done(1, n, leak);
      vectors++;
      if (n !== 33 || leak || HI !== ehi[k] || LO !== elo[k]) begin
        miscompares++;
        $display("FAIL div_%0d: cycle %0d leak=%b HI=%h LO=%h, expected 33 0 %h %h",
                 k, n, leak, HI, LO, ehi[k], elo[k]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_busy_ignore;
    int n; bit leak;
    issue(MD_MTHI, 32'h11, 32'h0);
    issue(MD_MTLO, 32'h22, 32'h0);
    issue(MD_DIVU, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    issue(MD_MTLO, 32'h0000ABCD, 32'h0);
    wait_for_done(6, n, leak);
    vectors++;
    if (n !== 33 || leak || HI !== 32'd2 || LO !== 32'd14) begin
      miscompares++;
      $display("FAIL busy_ignore: cycle %0d leak=%b HI=%h LO=%h, expected 33 0 00000002 0000000e", n, leak, HI, LO);
    end
    @(negedge clk);
  endtask

  task automatic test_flush;
    bit saw_done;
    issue(MD_MTHI, 32'd5, 32'h0);
    issue(MD_MTLO, 32'd9, 32'h0);
    issue(MD_MULT, 32'd4, 32'd4);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_run: busy=%b done=%b, expected 0 0", busy, done);
    end
    saw_done = 1'b0;
    repeat (40) begin
      if (done === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    vectors++;
    if (saw_done || HI !== 32'd5 || LO !== 32'd9) begin
      miscompares++;
      $display("FAIL flush_hold: saw_done=%b HI=%h LO=%h, expected 0 00000005 00000009", saw_done, HI, LO);
    end
    flush = 1'b1;
    issue(MD_MULT, 32'd4, 32'd4);
    flush = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_start: busy=%b, expected 0", busy);
    end
    issue(MD_MULT, 32'd4, 32'd4);
    repeat (31) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || HI !== 32'd5 || LO !== 32'd9) begin
      miscompares++;
      $display("FAIL flush_last: done=%b busy=%b HI=%h LO=%h, expected 0 0 00000005 00000009", done, busy, HI, LO);
    end
  endtask

  task automatic test_reset_mid_run;
    issue(MD_MULT, 32'd4, 32'd4);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (HI !== 32'h0 || LO !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async: HI=%h LO=%h busy=%b done=%b, expected all zero", HI, LO, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    vectors++;
    if (HI !== 32'h0 || LO !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_discard: HI=%h LO=%h busy=%b done=%b, expected all zero", HI, LO, busy, done);
    end
  endtask

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_mult();
    test_back_to_back();
    test_divide();
    test_busy_ignore();
    test_flush();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
Iterative multiply/divide unit that owns the architectural HI/LO registers. The EX stage writes these registers through MULT/MULTU/DIV/DIVU/MTHI/MTLO. The ALU reads LO (and HI) for MFLO/MFHI. `busy` drives the hazard unit, which stalls any MFHI/MFLO or new mul/div op while a computation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- ITER, 32, iterations per multiply/divide; must equal WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- md_start  in  1  one-cycle request; qualified by md_op.
- md_op  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 is reserved and treated as NONE.
- srcA  in  WIDTH  rs operand; multiplicand, dividend, or MTHI/MTLO data.
- srcB  in  WIDTH  rt operand; multiplier or divisor.
- flush  in  1  aborts the in-flight operation (exception or branch squash).
- HI  out  WIDTH  architectural HI register.
- LO  out  WIDTH  architectural LO register; feeds the ALU LO input.
- busy  out  1  computation in flight.
- done  out  1  one-cycle pulse: HI/LO were just updated by a mul/div.

Behaviour:
- Reset, asynchronous:
  - HI=0, LO=0, busy=0, done=0.
  - Iteration counter and datapath registers cleared.
  - An operation in progress is discarded.
- Accept condition: an op is accepted on an edge where md_start=1, busy=0 and flush=0.
  - md_start while busy=1 is ignored, including MTHI/MTLO. The hazard unit guarantees this does not occur.
  - md_op NONE or 7 is a no-op.
- MTHI/MTLO:
  - HI (or LO) takes srcA at the accept edge.
  - busy stays 0 and done stays 0.
- MULT/MULTU/DIV/DIVU, state machine IDLE -> RUN -> IDLE:
  - Accept edge E0:
    - Latch operand magnitudes; signed ops take the two's-complement absolute value.
    - Latch result sign(s) and the divide-by-zero flag.
    - Counter=0; busy=1 from E0.
  - RUN: one radix-2 step per edge, E1..E32.
    - Multiply: shift-add into a 2*WIDTH product register.
    - Divide: restoring subtract-shift, producing quotient and remainder.
  - At E32 (ITER edges after accept):
    - HI/LO are written.
    - busy falls and done=1 for the following cycle only.
    - A new md_start in that cycle is accepted (back-to-back ops allowed).
  - HI/LO hold their previous values for the whole RUN; no partial results are visible.
- Result rules:
  - MULT/MULTU: {HI,LO} = full 64-bit product. MULT negates the product if the operand signs differ.
  - DIV/DIVU: LO = quotient, HI = remainder.
    - Quotient is truncated toward zero.
    - Remainder carries the sign of the dividend.
    - Signed sign fix-up is applied at E32.
  - DIV -2^31 / -1: LO=0x80000000, HI=0 (wraps, no trap).
  - Divide by zero (DIV or DIVU): HI=srcA, LO=0xFFFFFFFF. Still takes ITER cycles for uniform timing.
- flush:
  - In RUN: at the next edge return to IDLE, busy=0, done=0; HI/LO are unchanged.
  - Concurrent with md_start: the start is dropped.
  - At edge E32: the flush wins and there is no HI/LO write.
- Reset mid-RUN: same effect as flush, plus HI/LO cleared.
- Cycle-count rule: done asserts exactly ITER+1 cycles after the cycle in which md_start was presented.

Decomposition:
- Shared package `md_pkg`:
  - Op code localparams MD_NONE..MD_MTLO.
  - WIDTH/ITER defaults.
  - Divide-by-zero LO constant 0xFFFFFFFF.
- One natural sub-module, `md_iter_core`:
  - Unsigned 32-step shift-add / restoring-subtract datapath, with inputs start, is_div, magnitudes.
  - Outputs 64-bit result and last_step.
  - The top level keeps the HI/LO registers, FSM, sign handling, flush and the MTHI/MTLO path.

Test Plan:
1. MULT srcA=0xFFFFFFFD (-3), srcB=7 -> busy for 32 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB, one-cycle done.
2. MULTU 0xFFFFFFFF * 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; a second MULTU 2*3 issued in the done cycle -> HI=0, LO=6 after 32 more cycles.
3. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU 100/0 -> HI=100, LO=0xFFFFFFFF.
4. Start from HI=0x11, LO=0x22; DIVU 100/7 accepted, MTLO 0xABCD presented at cycle 5 -> ignored; after 32 cycles HI=2, LO=14, never 0xABCD.
5. Starting HI=5, LO=9, MULT 4*4, flush at cycle 10 -> busy=0 next cycle, no done, HI=5, LO=9. Assert rst mid-RUN -> all outputs 0 immediately (asynchronous).
6. MTHI 0xDEAD then MTLO 0xBEEF on consecutive cycles -> HI=0xDEAD, LO=0xBEEF after each respective edge, busy and done never asserted.
